// File: rtl/eight_bit_count_arbiter_if.sv
// Requester-side bus of the shared-counter arbiter: per-requester request/op/data in,
// one-hot completion with result and wrap flag out.
interface eight_bit_count_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [2*NREQ-1:0] op;
    logic [8*NREQ-1:0] wdata;
    logic [NREQ-1:0]   ack;
    logic [7:0]        rdata;
    logic              wrap;
    logic              busy;

    modport master (output req, op, wdata, input ack, rdata, wrap, busy);
    modport slave  (input req, op, wdata, output ack, rdata, wrap, busy);
endinterface

// File: rtl/eight_bit_count_arbiter.sv
// Round-robin arbiter sharing one 8-bit up/down counter between NREQ requesters.
// Each grant drives a one-cycle counter strobe, then returns the result with ack and wrap.
module eight_bit_count_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    eight_bit_count_arbiter_if.slave bus,
    output logic                     cnt_clear,
    output logic                     cnt_load,
    output logic                     cnt_up_down,
    output logic                     cnt_en,
    output logic [7:0]               cnt_a,
    input  logic [7:0]               cnt_c
);
    localparam int unsigned DW = 8;
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_UP    = 2'b10;
    localparam logic [1:0] OP_DOWN  = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_CAPTURE} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     gidx_q, gidx_d;
    logic [1:0]        gop_q, gop_d;
    logic [DW-1:0]     gdata_q, gdata_d;
    logic              wrap_pend_q, wrap_pend_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              wrap_q, wrap_d;
    logic              busy_q, busy_d;

    logic [1:0]        op_arr [NREQ];
    logic [DW-1:0]     wd_arr [NREQ];
    logic [NREQ-1:0]   cand;
    logic [IW:0]       scan;
    logic              win_found;
    logic [IW-1:0]     win_idx;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign op_arr[g] = bus.op[2*g +: 2];
        assign wd_arr[g] = bus.wdata[DW*g +: DW];
    end

    // First pending requester at or after ptr; the one being acked this cycle is skipped.
    always_comb begin
        cand      = bus.req & ~ack_q;
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            scan = {1'b0, ptr_q} + (IW+1)'(i);
            if (scan >= (IW+1)'(NREQ)) begin
                scan = scan - (IW+1)'(NREQ);
            end
            if (!win_found && cand[scan[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (win_found) state_d = ST_ISSUE;
            ST_ISSUE:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Counter controls decode only from registered state and latched op.
    always_comb begin
        cnt_clear   = 1'b1;
        cnt_load    = 1'b0;
        cnt_up_down = 1'b1;
        cnt_en      = 1'b0;
        cnt_a       = '0;
        if (state_q == ST_ISSUE) begin
            cnt_en = 1'b1;
            case (gop_q)
                OP_CLEAR: cnt_clear = 1'b0;
                OP_LOAD: begin
                    cnt_load = 1'b1;
                    cnt_a    = gdata_q;
                end
                OP_UP:    cnt_up_down = 1'b1;
                OP_DOWN:  cnt_up_down = 1'b0;
            endcase
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        gop_d       = gop_q;
        gdata_d     = gdata_q;
        wrap_pend_d = wrap_pend_q;
        ack_d       = '0;
        rdata_d     = rdata_q;
        wrap_d      = wrap_q;
        busy_d      = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    gidx_d  = win_idx;
                    gop_d   = op_arr[win_idx];
                    gdata_d = wd_arr[win_idx];
                end
            end
            ST_ISSUE: begin
                // cnt_c still holds the pre-op value here.
                wrap_pend_d = ((gop_q == OP_UP)   && (cnt_c == 8'hFF)) ||
                              ((gop_q == OP_DOWN) && (cnt_c == 8'h00));
            end
            ST_CAPTURE: begin
                rdata_d = cnt_c;
                ack_d   = NREQ'(1) << gidx_q;
                wrap_d  = wrap_pend_q;
                ptr_d   = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= '0;
            gidx_q      <= '0;
            gop_q       <= '0;
            gdata_q     <= '0;
            wrap_pend_q <= 1'b0;
            ack_q       <= '0;
            rdata_q     <= '0;
            wrap_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            gop_q       <= gop_d;
            gdata_q     <= gdata_d;
            wrap_pend_q <= wrap_pend_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            wrap_q      <= wrap_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
    assign bus.wrap  = wrap_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_eight_bit_count_arbiter.sv
// Bench for eight_bit_count_arbiter: directed requests against a behavioural shared counter,
// expected responses queued at issue time and checked by a separate monitor on each ack.
module tb_eight_bit_count_arbiter;
    localparam int unsigned NREQ = 4;

    typedef struct packed {
        logic [NREQ-1:0] ack;
        logic [7:0]      rdata;
        logic            wrap;
    } resp_t;

    logic       clk;
    logic       rst_n;
    logic       cnt_clear, cnt_load, cnt_up_down, cnt_en;
    logic [7:0] cnt_a;
    logic [7:0] cnt_q;
    logic       preset_en;
    logic [7:0] preset_val;

    int         n_tests;
    int         n_fail;
    resp_t      sb_q [$];
    int         en_cnt;
    int         clr_cnt;
    int         ack_seen;
    logic [7:0] load_a;
    int         ack_at [NREQ];

    eight_bit_count_arbiter_if #(.NREQ(NREQ)) bus ();

    eight_bit_count_arbiter #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .bus         (bus),
        .cnt_clear   (cnt_clear),
        .cnt_load    (cnt_load),
        .cnt_up_down (cnt_up_down),
        .cnt_en      (cnt_en),
        .cnt_a       (cnt_a),
        .cnt_c       (cnt_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared counter instance, with a bench-side preset to set up start values.
    always_ff @(posedge clk) begin
        if (preset_en) begin
            cnt_q <= preset_val;
        end else if (cnt_en) begin
            if (!cnt_clear)       cnt_q <= 8'h00;
            else if (cnt_load)    cnt_q <= cnt_a;
            else if (cnt_up_down) cnt_q <= cnt_q + 8'h01;
            else                  cnt_q <= cnt_q - 8'h01;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        resp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (cnt_en) en_cnt++;
            if (cnt_en && !cnt_clear) clr_cnt++;
            if (cnt_en && cnt_load) load_a = cnt_a;
            if (bus.ack != '0) begin
                ack_seen++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_ack", 32'(bus.ack), 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    chk("ack",   32'(bus.ack),   32'(e.ack));
                    chk("rdata", 32'(bus.rdata), 32'(e.rdata));
                    chk("wrap",  32'(bus.wrap),  32'(e.wrap));
                end
            end
        end
    endtask

    task automatic expect_resp(input logic [NREQ-1:0] a, input logic [7:0] d, input logic w);
        resp_t r;
        r.ack   = a;
        r.rdata = d;
        r.wrap  = w;
        sb_q.push_back(r);
    endtask

    task automatic set_op(input int i, input logic [1:0] o, input logic [7:0] d);
        bus.op[2*i +: 2]    = o;
        bus.wdata[8*i +: 8] = d;
    endtask

    task automatic preset(input logic [7:0] v);
        @(negedge clk);
        preset_en  = 1'b1;
        preset_val = v;
        @(negedge clk);
        preset_en  = 1'b0;
    endtask

    task automatic wait_acks(input logic [NREQ-1:0] mask, input int budget);
        logic [NREQ-1:0] pend;
        pend = mask;
        for (int c = 1; c <= budget && pend != '0; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (bus.ack[i] && pend[i]) ack_at[i] = c;
            end
            pend    = pend & ~bus.ack;
            bus.req = bus.req & ~bus.ack;
        end
        chk("ack_timeout", 32'(pend), 32'h0);
    endtask

    task automatic run(input logic [NREQ-1:0] mask, input int budget);
        @(negedge clk);
        bus.req = bus.req | mask;
        wait_acks(mask, budget);
    endtask

    task automatic check_reset_outputs(input string p);
        chk({p, "_ack"},       32'(bus.ack),     32'h0);
        chk({p, "_rdata"},     32'(bus.rdata),   32'h0);
        chk({p, "_wrap"},      32'(bus.wrap),    32'h0);
        chk({p, "_busy"},      32'(bus.busy),    32'h0);
        chk({p, "_cnt_clear"}, 32'(cnt_clear),   32'h1);
        chk({p, "_cnt_load"},  32'(cnt_load),    32'h0);
        chk({p, "_cnt_en"},    32'(cnt_en),      32'h0);
        chk({p, "_cnt_ud"},    32'(cnt_up_down), 32'h1);
        chk({p, "_cnt_a"},     32'(cnt_a),       32'h0);
    endtask

    initial begin
        int base;
        n_tests    = 0;
        n_fail     = 0;
        en_cnt     = 0;
        clr_cnt    = 0;
        ack_seen   = 0;
        load_a     = 8'h00;
        bus.req    = '0;
        bus.op     = '0;
        bus.wdata  = '0;
        preset_en  = 1'b0;
        preset_val = 8'h00;
        rst_n      = 1'b0;
        for (int i = 0; i < NREQ; i++) ack_at[i] = 0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        // All four request together from ptr=0: served 0..3, three cycles apart.
        preset(8'h10);
        for (int i = 0; i < NREQ; i++) set_op(i, 2'b10, 8'h00);
        expect_resp(4'b0001, 8'h11, 1'b0);
        expect_resp(4'b0010, 8'h12, 1'b0);
        expect_resp(4'b0100, 8'h13, 1'b0);
        expect_resp(4'b1000, 8'h14, 1'b0);
        run(4'b1111, 20);
        chk("rr_at0", 32'(ack_at[0]), 32'd3);
        chk("rr_at1", 32'(ack_at[1]), 32'd6);
        chk("rr_at2", 32'(ack_at[2]), 32'd9);
        chk("rr_at3", 32'(ack_at[3]), 32'd12);

        // Single up from 00: latency and single strobe.
        preset(8'h00);
        base = en_cnt;
        expect_resp(4'b0001, 8'h01, 1'b0);
        run(4'b0001, 10);
        chk("lat_up", 32'(ack_at[0]), 32'd3);
        chk("en_once", 32'(en_cnt - base), 32'd1);

        // Wrap on up from FF, then down from 00.
        preset(8'hFF);
        expect_resp(4'b0010, 8'h00, 1'b1);
        run(4'b0010, 10);
        set_op(2, 2'b11, 8'h00);
        expect_resp(4'b0100, 8'hFF, 1'b1);
        run(4'b0100, 10);

        // Load A5 by requester 2, then clear by requester 1.
        set_op(2, 2'b01, 8'hA5);
        expect_resp(4'b0100, 8'hA5, 1'b0);
        run(4'b0100, 10);
        chk("load_cnt_a", 32'(load_a), 32'hA5);
        set_op(1, 2'b00, 8'h00);
        base = clr_cnt;
        expect_resp(4'b0010, 8'h00, 1'b0);
        run(4'b0010, 10);
        chk("clear_once", 32'(clr_cnt - base), 32'd1);

        // ptr is 2 after granting 1: req 0011 serves 0 first.
        set_op(0, 2'b10, 8'h00);
        set_op(1, 2'b10, 8'h00);
        preset(8'h20);
        expect_resp(4'b0001, 8'h21, 1'b0);
        expect_resp(4'b0010, 8'h22, 1'b0);
        run(4'b0011, 20);
        chk("ptr_at0", 32'(ack_at[0]), 32'd3);
        chk("ptr_at1", 32'(ack_at[1]), 32'd6);

        // Drop req and change op after grant: latched up-op still completes.
        preset(8'h30);
        set_op(3, 2'b10, 8'h00);
        expect_resp(4'b1000, 8'h31, 1'b0);
        @(negedge clk);
        bus.req = 4'b1000;
        @(negedge clk);
        bus.req = 4'b0000;
        set_op(3, 2'b11, 8'h00);
        wait_acks(4'b1000, 10);

        // Leave rdata/wrap/ptr nonzero, then reset during ISSUE.
        preset(8'h00);
        set_op(1, 2'b11, 8'h00);
        expect_resp(4'b0010, 8'hFF, 1'b1);
        run(4'b0010, 10);
        set_op(3, 2'b10, 8'h00);
        base = ack_seen;
        @(negedge clk);
        bus.req = 4'b1000;
        @(negedge clk);
        chk("issue_busy", 32'(bus.busy), 32'h1);
        chk("issue_en",   32'(cnt_en),   32'h1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        bus.req = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_no_ack", 32'(ack_seen - base), 32'd0);
        chk("abort_cnt",    32'(cnt_q),           32'hFF);

        // After reset ptr is 0: requester 0 ahead of 3.
        preset(8'h50);
        set_op(0, 2'b10, 8'h00);
        expect_resp(4'b0001, 8'h51, 1'b0);
        expect_resp(4'b1000, 8'h52, 1'b0);
        run(4'b1001, 20);
        chk("post_at0", 32'(ack_at[0]), 32'd3);
        chk("post_at3", 32'(ack_at[3]), 32'd6);

        repeat (4) @(negedge clk);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
